im_loader: RTL

Serial program loader for the instruction memory. It receives a framed byte stream on a UART line (8N1), assembles little-endian 32-bit instruction words, and writes them into the instruction ROM's write port starting at word 0. While a frame is in progress it holds the CPU in reset. It is the write-side counterpart to the CPU's instruction fetch and sits at the top level between the board's UART RX pin and the instruction memory.

---
 rtl/im_loader.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/im_loader.sv
// Serial instruction-memory loader: UART 8N1 byte receiver plus a frame FSM that writes
// little-endian words from address 0. Define IM_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte.
module im_loader #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              rx,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_din,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   HALF_M1   = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0]   FULL_M1   = CW'(DIV - 1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [8:0]      MAX_WORDS = 9'(1 << ADDR_W);
    localparam logic [ADDR_W:0] WL_ONE    = (ADDR_W + 1)'(1);
    localparam logic [7:0]      SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
    typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, FINISH} ldState_t;

    // ---------------- byte receiver ----------------
    logic [2:0]    r_rxSync;
    rxState_t      r_rxState, w_rxStateNext;
    logic [CW-1:0] r_bitCnt, w_bitCntNext;
    logic [2:0]    r_bitIdx, w_bitIdxNext;
    logic [7:0]    r_shift, w_shiftNext;
    logic          r_byteValid, w_byteValidNext;
    logic          r_frameErr, w_frameErrNext;
    logic          w_rx;
    logic          w_rxPrev;

    assign w_rx     = r_rxSync[1];
    assign w_rxPrev = r_rxSync[2];

    // Synchronizer flops reset high so that reset release never looks like a start edge.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_rxSync    <= 3'b111;
            r_rxState   <= RX_IDLE;
            r_bitCnt    <= '0;
            r_bitIdx    <= '0;
            r_shift     <= '0;
            r_byteValid <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            r_rxSync    <= {r_rxSync[1:0], rx};
            r_rxState   <= w_rxStateNext;
            r_bitCnt    <= w_bitCntNext;
            r_bitIdx    <= w_bitIdxNext;
            r_shift     <= w_shiftNext;
            r_byteValid <= w_byteValidNext;
            r_frameErr  <= w_frameErrNext;
        end
    end

    always_comb begin
        w_rxStateNext   = r_rxState;
        w_bitCntNext    = r_bitCnt + CNT_ONE;
        w_bitIdxNext    = r_bitIdx;
        w_shiftNext     = r_shift;
        w_byteValidNext = 1'b0;
        w_frameErrNext  = 1'b0;
        case (r_rxState)
            RX_IDLE: begin
                w_bitCntNext = '0;
                if (w_rxPrev && !w_rx) begin
                    w_rxStateNext = RX_START;
                end
            end
            RX_START: begin
                if (r_bitCnt == HALF_M1) begin
                    w_bitCntNext = '0;
                    w_bitIdxNext = '0;
                    w_rxStateNext = w_rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_bitCnt == FULL_M1) begin
                    w_bitCntNext = '0;
                    w_shiftNext  = {w_rx, r_shift[7:1]};
                    w_bitIdxNext = r_bitIdx + 3'd1;
                    if (r_bitIdx == 3'd7) begin
                        w_rxStateNext = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (r_bitCnt == FULL_M1) begin
                    w_bitCntNext    = '0;
                    w_rxStateNext   = RX_IDLE;
                    w_byteValidNext = w_rx;
                    w_frameErrNext  = !w_rx;
                end
            end
            default: begin
                w_rxStateNext = RX_IDLE;
            end
        endcase
    end

    // ---------------- frame FSM ----------------
    ldState_t          r_state, w_stateNext;
    logic [ADDR_W:0]   r_target, w_targetNext;
    logic [1:0]        r_byteIdx, w_byteIdxNext;
    logic [31:0]       r_word, w_wordNext;
    logic              r_imWe, w_imWeNext;
    logic [ADDR_W-1:0] r_imAddr, w_imAddrNext;
    logic [31:0]       r_imDin, w_imDinNext;
    logic              r_cpuHold, w_cpuHoldNext;
    logic              r_err, w_errNext;
    logic [ADDR_W:0]   r_wordsLoaded, w_wordsLoadedNext;
    logic [ADDR_W:0]   w_wlInc;
    logic [8:0]        w_nExt, w_nClamped;
    logic [31:0]       w_wordMerged;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]        r_checksum, w_checksumNext;
`endif

    assign w_wlInc    = r_wordsLoaded + WL_ONE;
    assign w_nExt     = {1'b0, r_shift};
    assign w_nClamped = ((w_nExt == 9'd0) || (w_nExt > MAX_WORDS)) ? MAX_WORDS : w_nExt;

    always_comb begin
        w_wordMerged = r_word;
        case (r_byteIdx)
            2'd0:    w_wordMerged[7:0]   = r_shift;
            2'd1:    w_wordMerged[15:8]  = r_shift;
            2'd2:    w_wordMerged[23:16] = r_shift;
            default: w_wordMerged[31:24] = r_shift;
        endcase
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_state       <= IDLE;
            r_target      <= '0;
            r_byteIdx     <= '0;
            r_word        <= '0;
            r_imWe        <= 1'b0;
            r_imAddr      <= '0;
            r_imDin       <= '0;
            r_cpuHold     <= 1'b0;
            r_err         <= 1'b0;
            r_wordsLoaded <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            r_checksum    <= '0;
`endif
        end else begin
            r_state       <= w_stateNext;
            r_target      <= w_targetNext;
            r_byteIdx     <= w_byteIdxNext;
            r_word        <= w_wordNext;
            r_imWe        <= w_imWeNext;
            r_imAddr      <= w_imAddrNext;
            r_imDin       <= w_imDinNext;
            r_cpuHold     <= w_cpuHoldNext;
            r_err         <= w_errNext;
            r_wordsLoaded <= w_wordsLoadedNext;
`ifdef IM_LOADER_CHECKSUM_EN
            r_checksum    <= w_checksumNext;
`endif
        end
    end

    // A framing error mid-frame aborts straight to IDLE; already-written words are left alone.
    always_comb begin
        w_stateNext       = r_state;
        w_targetNext      = r_target;
        w_byteIdxNext     = r_byteIdx;
        w_wordNext        = r_word;
        w_imWeNext        = 1'b0;
        w_imAddrNext      = r_imAddr;
        w_imDinNext       = r_imDin;
        w_cpuHoldNext     = r_cpuHold;
        w_errNext         = r_err;
        w_wordsLoadedNext = r_wordsLoaded;
`ifdef IM_LOADER_CHECKSUM_EN
        w_checksumNext    = r_checksum;
`endif
        case (r_state)
            IDLE: begin
                if (r_byteValid && (r_shift == SYNC_BYTE)) begin
                    w_stateNext       = COUNT;
                    w_cpuHoldNext     = 1'b1;
                    w_errNext         = 1'b0;
                    w_wordsLoadedNext = '0;
                    w_byteIdxNext     = '0;
`ifdef IM_LOADER_CHECKSUM_EN
                    w_checksumNext    = '0;
`endif
                end
            end
            COUNT: begin
                if (r_frameErr) begin
                    w_errNext     = 1'b1;
                    w_cpuHoldNext = 1'b0;
                    w_stateNext   = IDLE;
                end else if (r_byteValid) begin
                    w_targetNext = w_nClamped[ADDR_W:0];
                    w_stateNext  = DATA;
                end
            end
            DATA: begin
                if (r_frameErr) begin
                    w_errNext     = 1'b1;
                    w_cpuHoldNext = 1'b0;
                    w_stateNext   = IDLE;
                end else if (r_byteValid) begin
                    w_wordNext    = w_wordMerged;
                    w_byteIdxNext = r_byteIdx + 2'd1;
`ifdef IM_LOADER_CHECKSUM_EN
                    w_checksumNext = r_checksum ^ r_shift;
`endif
                    if (r_byteIdx == 2'd3) begin
                        w_imWeNext        = 1'b1;
                        w_imAddrNext      = r_wordsLoaded[ADDR_W-1:0];
                        w_imDinNext       = w_wordMerged;
                        w_wordsLoadedNext = w_wlInc;
                        if (w_wlInc == r_target) begin
`ifdef IM_LOADER_CHECKSUM_EN
                            w_stateNext   = CHECK;
`else
                            w_stateNext   = FINISH;
                            w_cpuHoldNext = 1'b0;
`endif
                        end
                    end
                end
            end
            CHECK: begin
                if (r_frameErr) begin
                    w_errNext     = 1'b1;
                    w_cpuHoldNext = 1'b0;
                    w_stateNext   = IDLE;
                end else if (r_byteValid) begin
`ifdef IM_LOADER_CHECKSUM_EN
                    if (r_shift != r_checksum) begin
                        w_errNext = 1'b1;
                    end
`endif
                    w_cpuHoldNext = 1'b0;
                    w_stateNext   = FINISH;
                end
            end
            FINISH: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign im_we        = r_imWe;
    assign im_addr      = r_imAddr;
    assign im_din       = r_imDin;
    assign cpu_hold     = r_cpuHold;
    assign done         = (r_state == FINISH);
    assign err          = r_err;
    assign words_loaded = r_wordsLoaded;

endmodule
